// File: rtl/usart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : usart_rx_fifo
// Purpose : Handshakes bytes out of usart_rx into a first-word-fall-through
//           FIFO (8 data bits + error flag per entry) for the CPU-side reader.
// Revision: 1.0 - initial release
// ============================================================================
module usart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  bit_clock_x16,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_available,
    input  logic                  rx_error,
    output logic                  rx_acknowledge,
    output logic [7:0]            read_data,
    output logic                  read_error,
    output logic                  read_valid,
    input  logic                  read_strobe,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    input  logic                  clear_errors
);

    localparam int                c_DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL = (DEPTH_LOG2 + 1)'(c_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_capture;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2-1:0]   r_rd_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    r_overrun;
    logic [8:0]              r_mem [c_DEPTH];
    logic [8:0]              w_head;

    always_ff @(posedge bit_clock_x16 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // One capture per rx_available assertion: ACK holds until usart_rx lets go.
    always_comb begin
        w_state_next   = r_state;
        rx_acknowledge = 1'b0;
        w_capture      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rx_available) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                rx_acknowledge = 1'b1;
                if (!rx_available) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign read_valid = (r_count != '0);
    assign w_pop      = read_strobe && read_valid;
    // A same-cycle pop frees a slot, so a full FIFO can still accept the byte.
    assign w_push     = w_capture && ((r_count != c_FULL) || w_pop);
    assign w_drop     = w_capture && !w_push;

    always_ff @(posedge bit_clock_x16) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {rx_error, rx_data};
        end
    end

    always_ff @(posedge bit_clock_x16 or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (DEPTH_LOG2)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (DEPTH_LOG2)'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
            end
            // A fresh drop wins over a simultaneous clear.
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_errors) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign read_data  = read_valid ? w_head[7:0] : 8'h00;
    assign read_error = read_valid ? w_head[8] : 1'b0;
    assign count      = r_count;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_usart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_usart_rx_fifo
// Purpose : Self-checking bench: vector table, directed corner sequences and
//           randomized traffic against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_usart_rx_fifo;

    localparam int c_DEPTH_LOG2 = 4;
    localparam int c_DEPTH      = 2 ** c_DEPTH_LOG2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [7:0]            rx_data = 8'h00;
    logic                  rx_available = 1'b0;
    logic                  rx_error = 1'b0;
    logic                  rx_acknowledge;
    logic [7:0]            read_data;
    logic                  read_error;
    logic                  read_valid;
    logic                  read_strobe = 1'b0;
    logic [c_DEPTH_LOG2:0] count;
    logic                  overrun;
    logic                  clear_errors = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queue, overrun flag, and "this assertion already taken".
    logic [8:0] m_q[$];
    bit         m_ovr;
    bit         m_taken;

    usart_rx_fifo #(.DEPTH_LOG2(c_DEPTH_LOG2)) dut (
        .bit_clock_x16  (clk),
        .reset          (rst),
        .rx_data        (rx_data),
        .rx_available   (rx_available),
        .rx_error       (rx_error),
        .rx_acknowledge (rx_acknowledge),
        .read_data      (read_data),
        .read_error     (read_error),
        .read_valid     (read_valid),
        .read_strobe    (read_strobe),
        .count          (count),
        .overrun        (overrun),
        .clear_errors   (clear_errors)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         avail;
        logic [7:0] data;
        bit         err;
        bit         strobe;
        bit         clr;
        bit         e_ack;
        bit         e_valid;
        logic [7:0] e_data;
        bit         e_err;
        int         e_count;
        bit         e_ovr;
    } vec_t;

    vec_t tbl[12];

    task automatic check_val(string name, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_ovr   = 1'b0;
        m_taken = 1'b0;
    endfunction

    function automatic void model_step(bit avail, logic [7:0] d, bit e, bit strobe, bit clr);
        bit pop;
        bit cap;
        pop = strobe && (m_q.size() > 0);
        cap = avail && !m_taken;
        if (pop) void'(m_q.pop_front());
        if (clr) m_ovr = 1'b0;
        if (cap) begin
            if (m_q.size() < c_DEPTH) m_q.push_back({e, d});
            else m_ovr = 1'b1;
        end
        m_taken = cap ? 1'b1 : (m_taken && avail);
    endfunction

    task automatic check_model(string name);
        logic [8:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 9'h000;
        check_val({name, ".state"},
                  {rx_acknowledge, read_valid, read_error, read_data, count, overrun},
                  {m_taken, m_q.size() > 0, head[8], head[7:0],
                   5'(m_q.size()), m_ovr});
    endtask

    // Called at a negedge: drives inputs, steps one rising edge, checks at the next negedge.
    task automatic cycle(string name, bit avail, logic [7:0] d, bit e, bit strobe, bit clr);
        rx_available = avail;
        rx_data      = d;
        rx_error     = e;
        read_strobe  = strobe;
        clear_errors = clr;
        @(posedge clk);
        model_step(avail, d, e, strobe, clr);
        @(negedge clk);
        check_model(name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push_byte(logic [7:0] d);
        cycle("push", 1'b1, d, 1'b0, 1'b0, 1'b0);
        cycle("push_rel", 1'b0, d, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0]  = '{"single_cap",  1, 8'h75, 0, 0, 0, 1, 1, 8'h75, 0, 1, 0};
        tbl[1]  = '{"single_hold1",1, 8'h75, 0, 0, 0, 1, 1, 8'h75, 0, 1, 0};
        tbl[2]  = '{"single_hold2",1, 8'h75, 0, 0, 0, 1, 1, 8'h75, 0, 1, 0};
        tbl[3]  = '{"single_hold3",1, 8'h75, 0, 0, 0, 1, 1, 8'h75, 0, 1, 0};
        tbl[4]  = '{"single_hold4",1, 8'h75, 0, 0, 0, 1, 1, 8'h75, 0, 1, 0};
        tbl[5]  = '{"single_rel",  0, 8'h75, 0, 0, 0, 0, 1, 8'h75, 0, 1, 0};
        tbl[6]  = '{"single_pop",  0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[7]  = '{"err_cap",     1, 8'hF5, 1, 0, 0, 1, 1, 8'hF5, 1, 1, 0};
        tbl[8]  = '{"err_rel",     0, 8'hF5, 0, 0, 0, 0, 1, 8'hF5, 1, 1, 0};
        tbl[9]  = '{"err_pop",     0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[10] = '{"pop_empty",   0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0};
        tbl[11] = '{"clr_idle",    0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0};

        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_val("reset_outputs",
                  {rx_acknowledge, read_valid, read_error, read_data, count, overrun}, 0);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].name, tbl[i].avail, tbl[i].data, tbl[i].err, tbl[i].strobe, tbl[i].clr);
            check_val({tbl[i].name, ".vec"},
                      {rx_acknowledge, read_valid, read_error, read_data, count, overrun},
                      {tbl[i].e_ack, tbl[i].e_valid, tbl[i].e_err, tbl[i].e_data,
                       5'(tbl[i].e_count), tbl[i].e_ovr});
        end

        // Overrun: fill, drop one, drain in order, clear
        for (int i = 0; i < c_DEPTH; i++) push_byte(8'(i));
        check_val("full_count", count, c_DEPTH);
        cycle("ovr_push", 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        check_val("ovr_ack", rx_acknowledge, 1);
        check_val("ovr_flag", overrun, 1);
        check_val("ovr_count", count, c_DEPTH);
        cycle("ovr_rel", 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < c_DEPTH; i++) begin
            check_val("drain_order", read_data, i);
            cycle("drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        check_val("drain_empty", {read_valid, count}, 0);
        check_val("ovr_sticky", overrun, 1);
        cycle("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check_val("ovr_cleared", overrun, 0);

        // Full with concurrent pop (pointers have wrapped by now)
        for (int i = 0; i < c_DEPTH; i++) push_byte(8'(8'h30 + i));
        cycle("full_pop_push", 1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        check_val("fpp_count", count, c_DEPTH);
        check_val("fpp_ovr", overrun, 0);
        check_val("fpp_head", read_data, 8'h31);
        cycle("fpp_rel", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < c_DEPTH; i++) begin
            check_val("fpp_order", read_data, 8'h30 + i);
            cycle("fpp_drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        check_val("fpp_last", read_data, 8'h55);
        cycle("fpp_final", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Empty+1 with concurrent pop and push
        push_byte(8'h11);
        cycle("e1_pop_push", 1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
        check_val("e1_count", count, 1);
        check_val("e1_head", read_data, 8'h22);
        cycle("e1_rel", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset while in ACK, rx_available stays high
        cycle("rst_ack_cap", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        check_val("rst_pre_ack", rx_acknowledge, 1);
        #2 rst = 1'b1;
        #1;
        check_val("rst_async",
                  {rx_acknowledge, read_valid, read_error, read_data, count, overrun}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle("rst_recap", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        check_val("rst_recap_cnt", {rx_acknowledge, count, read_data}, {1'b1, 5'd1, 8'h33});
        cycle("rst_hold", 1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        check_val("rst_no_dup", count, 1);
        cycle("rst_rel", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized traffic against the model; first half fills, second drains
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit a, s, c, e;
            a = ($urandom_range(0, 3) != 0);
            s = (n < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
            c = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 7) == 0);
            cycle("rand", a, 8'($urandom), e, s, c);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
